// File: rtl/priority_scan_pkg.sv
// Shared types and helpers for the priority scan encoder.
// Provides the FSM state enum and a popcount helper.
package priority_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        NONE
    } state_t;

    localparam int MAX_WIDTH = 256;

    // Callers zero-extend their vector to MAX_WIDTH bits.
    function automatic int popcount(input logic [MAX_WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/priority_scan_encoder_pick.sv
// Combinational find-first picker for a request vector.
// Ports: vec in, idx (first set bit per MSB_FIRST), any, onehot.
module priority_pick #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             onehot
);

    // Later matches overwrite earlier ones, so the scan direction
    // picks which end wins.
    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) idx = i[IDX_W-1:0];
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) idx = i[IDX_W-1:0];
            end
        end
    end

    assign any    = |vec;
    assign onehot = any && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/priority_scan_encoder.sv
// Sequential priority encoder: captures a request vector, then emits
// one beat per set bit in priority order. Ports: clk, rst, in_valid/
// in_ready/in_req (capture), out_valid/out_ready/out_idx/out_last/
// out_none/out_count (beats).
module priority_scan_encoder
    import priority_scan_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic [IDX_W:0]   out_count
);

    state_t             state;
    logic [WIDTH-1:0]   pending;
    logic [IDX_W:0]     count_q;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               pick_one;
    logic [MAX_WIDTH-1:0] req_ext;
    logic               fire_out;
    logic               final_beat;
    logic               accept;

    priority_pick #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_pick (
        .vec    (pending),
        .idx    (pick_idx),
        .any    (pick_any),
        .onehot (pick_one)
    );

    always_comb begin
        req_ext = '0;
        req_ext[WIDTH-1:0] = in_req;
    end

    assign out_valid  = (state == SCAN) || (state == NONE);
    assign out_none   = (state == NONE);
    assign out_last   = out_none || ((state == SCAN) && pick_one);
    assign out_idx    = (state == SCAN) ? pick_idx : '0;
    assign out_count  = count_q;

    assign fire_out   = out_valid && out_ready;
    assign final_beat = fire_out && out_last;

    // Final-beat handshake reopens the input for a bubble-free
    // back-to-back capture; held low while reset is asserted.
    assign in_ready   = !rst && ((state == IDLE) || final_beat);
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            count_q <= '0;
        end else begin
            if (fire_out && (state == SCAN) && pick_any) begin
                pending[pick_idx] <= 1'b0;
            end
            if (accept) begin
                pending <= in_req;
                count_q <= (IDX_W+1)'(popcount(req_ext));
                state   <= (|in_req) ? SCAN : NONE;
            end else if (final_beat) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Directed bench for priority_scan_encoder.
// Drives and samples on the falling clock edge.
module tb_priority_scan_encoder;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_req;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        out_none;
    logic [4:0]  out_count;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  in_req8;
    logic        out_valid8;
    logic        out_ready8;
    logic [2:0]  out_idx8;
    logic        out_last8;
    logic        out_none8;
    logic [3:0]  out_count8;

    int n_cmp;
    int n_err;

    priority_scan_encoder #(
        .WIDTH     (16),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_req    (in_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none),
        .out_count (out_count)
    );

    priority_scan_encoder #(
        .WIDTH     (8),
        .MSB_FIRST (1'b0)
    ) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_req    (in_req8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_idx   (out_idx8),
        .out_last  (out_last8),
        .out_none  (out_none8),
        .out_count (out_count8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks the current 16-bit beat, then advances one cycle.
    task automatic beat(input string tag, input int idx, input bit last,
                        input bit none, input int cnt);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".idx"},   32'(out_idx),   32'(idx));
        check({tag, ".last"},  32'(out_last),  32'(last));
        check({tag, ".none"},  32'(out_none),  32'(none));
        check({tag, ".cnt"},   32'(out_count), 32'(cnt));
        @(negedge clk);
    endtask

    task automatic send(input string tag, input logic [15:0] v);
        in_valid = 1'b1;
        in_req   = v;
        #1;
        check({tag, ".rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        check({tag, ".ov"}, 32'(out_valid), 32'd0);
        check({tag, ".ir"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_req     = '0;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        in_req8    = '0;
        out_ready8 = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst.ir",  32'(in_ready),  32'd0);
        check("rst.ov",  32'(out_valid), 32'd0);
        check("rst.cnt", 32'(out_count), 32'd0);
        rst = 1'b0;
        #1;
        idle_chk("post_rst");
        @(negedge clk);

        // Single vector, three beats
        send("c001", 16'hC001);
        beat("c001.b0", 15, 1'b0, 1'b0, 3);
        beat("c001.b1", 14, 1'b0, 1'b0, 3);
        beat("c001.b2", 0,  1'b1, 1'b0, 3);
        idle_chk("c001.end");

        // All-zero vector
        send("zero", 16'h0000);
        beat("zero.b0", 0, 1'b1, 1'b1, 0);
        idle_chk("zero.end");

        // Backpressure holds the first beat
        out_ready = 1'b0;
        send("bp", 16'h0006);
        for (int i = 0; i < 3; i++) begin
            check("bp.hold_ir", 32'(in_ready), 32'd0);
            beat("bp.hold", 2, 1'b0, 1'b0, 2);
        end
        out_ready = 1'b1;
        beat("bp.b0", 2, 1'b0, 1'b0, 2);
        beat("bp.b1", 1, 1'b1, 1'b0, 2);
        idle_chk("bp.end");

        // Back-to-back capture on the final-beat cycle
        in_valid = 1'b1;
        in_req   = 16'h8000;
        @(negedge clk);
        in_req = 16'h0001;
        #1;
        check("b2b.ir_final", 32'(in_ready), 32'd1);
        check("b2b.b0.idx",   32'(out_idx),  32'd15);
        check("b2b.b0.last",  32'(out_last), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        beat("b2b.b1", 0, 1'b1, 1'b0, 1);
        idle_chk("b2b.end");

        // Reset in the middle of a scan
        send("mid", 16'hA5A5);
        check("mid.b0.idx", 32'(out_idx),   32'd15);
        check("mid.b0.cnt", 32'(out_count), 32'd8);
        #2;
        rst = 1'b1;
        #1;
        check("mid.rst.ir",   32'(in_ready),  32'd0);
        check("mid.rst.ov",   32'(out_valid), 32'd0);
        check("mid.rst.idx",  32'(out_idx),   32'd0);
        check("mid.rst.last", 32'(out_last),  32'd0);
        check("mid.rst.none", 32'(out_none),  32'd0);
        check("mid.rst.cnt",  32'(out_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        idle_chk("mid.rel");
        @(negedge clk);
        idle_chk("mid.stale");

        // LSB-first, 8-bit instance
        in_valid8 = 1'b1;
        in_req8   = 8'b1001_0010;
        #1;
        check("w8.rdy", 32'(in_ready8), 32'd1);
        @(negedge clk);
        in_valid8 = 1'b0;
        check("w8.b0.idx",  32'(out_idx8),   32'd1);
        check("w8.b0.last", 32'(out_last8),  32'd0);
        check("w8.b0.cnt",  32'(out_count8), 32'd3);
        @(negedge clk);
        check("w8.b1.idx",  32'(out_idx8),   32'd4);
        check("w8.b1.last", 32'(out_last8),  32'd0);
        @(negedge clk);
        check("w8.b2.idx",  32'(out_idx8),   32'd7);
        check("w8.b2.last", 32'(out_last8),  32'd1);
        check("w8.b2.cnt",  32'(out_count8), 32'd3);
        @(negedge clk);
        check("w8.end.ov",  32'(out_valid8), 32'd0);
        check("w8.end.ir",  32'(in_ready8),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/priority_scan_encoder.md
# priority_scan_encoder

Parametrised, sequential successor to the team's 16-bit combinational priority encoder. Captures a WIDTH-bit request vector through a valid/ready handshake, then emits the index of every set bit, one per output beat, in priority order (highest bit first by default). Software-visible "no request" and "last index" flags replace the old magic codes. Sits between the input pins/register file and any consumer that must service all pending requests, not just the top one.

## Interface
- WIDTH, 16: request vector width; legal range 2..256.
- IDX_W, $clog2(WIDTH): index width; derived, not overridden.
- MSB_FIRST, 1: 1 = highest set bit emitted first; 0 = lowest set bit first.
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- in_valid  in  1  request vector offered.
- in_ready  out  1  block can accept a vector this cycle.
- in_req  in  WIDTH  request vector; sampled only on in_valid && in_ready.
- out_valid  out  1  out_idx/out_last/out_none/out_count valid.
- out_ready  in  1  consumer accepts current beat.
- out_idx  out  IDX_W  index of current highest-priority pending bit.
- out_last  out  1  current beat is the final beat for this vector.
- out_none  out  1  captured vector was all-zero (single beat, out_idx = 0).
- out_count  out  IDX_W+1  popcount of the captured vector; constant for all beats of one vector.

## Operation
- States: IDLE, SCAN, NONE.
- IDLE: in_ready = 1, out_valid = 0. On accept: pending <= in_req, out_count <= popcount(in_req); next state SCAN if in_req != 0, else NONE.
- SCAN: out_valid = 1; out_idx = find-first of pending per MSB_FIRST; out_last = 1 iff pending has exactly one set bit; out_none = 0. On out_ready: clear pending[out_idx]; if out_last, leave SCAN.
- NONE: out_valid = 1, out_none = 1, out_last = 1, out_idx = 0, out_count = 0. On out_ready, leave NONE.
- Leaving SCAN/NONE (final beat handshaken): in_ready = 1 in that same cycle; if in_valid also high the new vector is captured and next state is SCAN/NONE per the new vector (back-to-back, no bubble); otherwise IDLE.
- in_ready = 0 in SCAN/NONE except on the final-beat handshake cycle as above.
- out_valid, once high, stays high and out_idx/out_last/out_none/out_count stay stable until out_ready.
- in_req changing while not accepted has no effect.
- Outputs during rst high: in_ready = 0, out_valid = 0, out_idx = 0, out_last = 0, out_none = 0, out_count = 0; state IDLE, pending = 0.
- Reset mid-vector: remaining beats discarded; first cycle after rst falls is IDLE with in_ready = 1.

## Timing
- Accept in cycle N -> first beat out_valid in cycle N+1.
- Vector with k set bits (k >= 1) occupies exactly k beats; with out_ready held high, beats in cycles N+1..N+k, next vector acceptable in cycle N+k.
- All-zero vector: exactly one beat.
- out_idx, out_last combinational from registered pending only (no in_* to out_* combinational path); in_ready depends on state, out_ready and out_last.

## Structure
- Package priority_scan_pkg: state enum (IDLE, SCAN, NONE) and a popcount function.
- Sub-module priority_pick (combinational, params WIDTH, MSB_FIRST): inputs vector, outputs index, any, onehot (exactly one set bit). Instantiated once on pending.
- Top holds FSM, pending register, out_count register, handshake logic.

## Test plan
- Reset: assert rst mid-SCAN with in_req = 16'hA5A5 captured -> all outputs 0 while high; after release in_ready = 1, out_valid = 0, no stale beats.
- Single vector, out_ready = 1: in_req = 16'hC001 -> beats idx 15, 14, 0; out_last only on idx 0; out_count = 3 on all beats.
- Zero vector: in_req = 16'h0000 -> one beat, out_none = 1, out_last = 1, out_idx = 0, out_count = 0.
- Backpressure: in_req = 16'h0006, out_ready low 3 cycles -> out_idx = 2 held stable, then idx 2, idx 1 (last); no beat lost or duplicated.
- Back-to-back: in_valid held high with 16'h8000 then 16'h0001 -> beats idx 15 (last), idx 0 (last) in consecutive cycles, second vector accepted on the first's final-beat cycle.
- MSB_FIRST = 0, WIDTH = 8: in_req = 8'b1001_0010 -> beats idx 1, 4, 7; out_count = 3.
